store_size_unit: RTL and testbench
==================================

// Module: store_size_unit
// PURPOSE
//  Store-path partner of the load-size component in the multicycle MIPS datapath.
//  Performs SW/SH/SB to data memory. SW is a direct write.
//  SH/SB run a read-modify-write sequence: read the word, merge the low half/byte
//  of the store data, write back. The control unit pulses start and waits for done.
// PARAMETERS
//  MEM_LATENCY  1  cycles from mem_addr valid to mem_rdata valid (legal 1..7)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  start       in   1   begin store; sampled only in IDLE
//  ss_ctrl     in   2   00 word, 01 half, 10 byte, 11 illegal
//  addr        in   32  word-aligned target address
//  store_data  in   32  data to store (register B)
//  mem_rdata   in   32  memory read data
//  mem_addr    out  32  memory address
//  mem_wdata   out  32  memory write data
//  mem_wr      out  1   memory write enable, one-cycle pulse
//  busy        out  1   high from the cycle after start until done
//  done        out  1   one-cycle completion pulse
//  illegal     out  1   pulses with done when ss_ctrl==11; no write occurs
// BEHAVIOUR
//  Reset (async, reset==0) forces the following, immediately and without a clock:
//   state=IDLE, wait counter=0, mem_addr=0, mem_wdata=0, mem_wr=0, busy=0,
//   done=0, illegal=0.
//  On start in IDLE, latch addr, store_data and ss_ctrl.
//   Later input changes have no effect until the next IDLE.
//  start while busy is ignored; it is not queued.
//  States:
//   IDLE -> WRITE (word) | READ (half/byte) | DONE (illegal)
//   READ: mem_addr=latched addr; hold for MEM_LATENCY cycles.
//     Sample mem_rdata at the clock edge ending the last READ cycle.
//   WRITE: mem_wr=1, mem_addr=latched addr, mem_wdata=merged word; lasts one cycle.
//   DONE: done=1 for one cycle (illegal=1 too if ss_ctrl==11); then -> IDLE.
//  Merge (combinational, widths exact, no sign handling):
//   word: store_data
//   half: {rd[31:16], store_data[15:0]}
//   byte: {rd[31:8],  store_data[7:0]}
//  Latency, with start sampled at edge k and L = MEM_LATENCY:
//   word:    mem_wr in cycle k+1, done in cycle k+2
//   half/byte: READ in cycles k+1..k+L, mem_wr in k+L+1, done in k+L+2
//   illegal: done and illegal in cycle k+1; mem_wr is never asserted
//  busy=1 in every non-IDLE state. mem_wr is high only in WRITE.
//  start in the DONE cycle is ignored. Back-to-back stores need start in IDLE.
//  Reset mid-sequence aborts the store. mem_wr drops immediately and no partial
//   write follows reset release.
//  Counter: 3 bits; must not wrap for L<=7.
// STRUCTURE
//  Shared defines include (used by the load-size and store-size paths):
//   SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10, SZ_ILL=2'b11.
//  State encodings are localparams inside this module.
//  One sub-module: ss_merge. It is purely combinational:
//   (ss_ctrl, store_data, rdata) -> wdata.
//  FSM and latches live in store_size_unit.
// TESTING
//  1. reset=0 at t0 -> all outputs 0; with start=1 held, no activity until reset=1.
//  2. SW with addr=0x40, store_data=0xDEADBEEF
//     -> mem_wr at k+1 with mem_addr=0x40, wdata=0xDEADBEEF; done at k+2.
//  3. SH with mem_rdata=0x11223344, store_data=0xAAAABBBB, L=1
//     -> READ k+1, mem_wr k+2 with wdata=0x1122BBBB, done k+3.
//  4. SB with rdata=0x11223344, store_data=0x000000CC, L=3
//     -> READ k+1..k+3, wdata=0x112233CC at k+4, done k+5.
//  5. ss_ctrl=11 -> done=illegal=1 at k+1, mem_wr never 1;
//     start pulsed during busy of a SH -> ignored, only one write.
//  6. reset asserted during READ of an SB -> outputs 0 asynchronously;
//     after release, no mem_wr until a new start.

Source files
------------

// File: rtl/store_size_unit_pkg.sv
// Size codes shared by the load-size and store-size datapath units.
package store_size_unit_pkg;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
endpackage

// File: rtl/ss_merge.sv
// Combinational merge of store data into a read word for SW/SH/SB.
module ss_merge
  import store_size_unit_pkg::*;
(
  input  logic [1:0]  ss_ctrl,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata
);

  always_comb begin
    wdata = store_data;
    case (ss_ctrl)
      SZ_HALF: wdata = {rdata[31:16], store_data[15:0]};
      SZ_BYTE: wdata = {rdata[31:8], store_data[7:0]};
      default: wdata = store_data;
    endcase
  end

endmodule

// File: rtl/store_size_unit.sv
// Store-size sequencer: direct SW, read-modify-write SH/SB, illegal-size reporting.
//  state | meaning
//  IDLE  | waiting for start; inputs latched on start
//  READ  | mem_addr driven, waiting MEM_LATENCY cycles for read data
//  WRITE | one-cycle mem_wr with merged word
//  DONE  | one-cycle done (and illegal) pulse
module store_size_unit
  import store_size_unit_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  ss_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic [1:0]  ctrl_q;
  logic [31:0] data_q;
  logic [1:0]  sel_ctrl;
  logic [31:0] sel_data;
  logic [31:0] merged;

  // In IDLE the merge sees the live inputs so a word store can write next cycle.
  assign sel_ctrl = (state == S_IDLE) ? ss_ctrl : ctrl_q;
  assign sel_data = (state == S_IDLE) ? store_data : data_q;

  ss_merge u_merge (
    .ss_ctrl    (sel_ctrl),
    .store_data (sel_data),
    .rdata      (mem_rdata),
    .wdata      (merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ctrl_q    <= '0;
      data_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      mem_wr  <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ctrl_q   <= ss_ctrl;
            data_q   <= store_data;
            busy     <= 1'b1;
            case (ss_ctrl)
              SZ_WORD: begin
                state     <= S_WRITE;
                mem_addr  <= addr;
                mem_wdata <= merged;
                mem_wr    <= 1'b1;
              end
              SZ_ILL: begin
                state   <= S_DONE;
                done    <= 1'b1;
                illegal <= 1'b1;
              end
              default: begin
                state    <= S_READ;
                mem_addr <= addr;
                cnt      <= LAT_LAST;
              end
            endcase
          end
        end
        S_READ: begin
          // Terminal count: mem_rdata is valid at this edge.
          if (cnt == 3'd0) begin
            state     <= S_WRITE;
            mem_wdata <= merged;
            mem_wr    <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_WRITE: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_size_unit.sv
// Bench for store_size_unit: two instances (latency 1 and 3) against a word-memory model.
module tb_store_size_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  ss_ctrl;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] rdata    [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata[2];
  logic        mem_wr   [2];
  logic        busy     [2];
  logic        done     [2];
  logic        illegal  [2];

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  store_size_unit #(.MEM_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .start(start), .ss_ctrl(ss_ctrl), .addr(addr),
    .store_data(store_data), .mem_rdata(rdata[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_wr(mem_wr[0]), .busy(busy[0]),
    .done(done[0]), .illegal(illegal[0])
  );

  store_size_unit #(.MEM_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .start(start), .ss_ctrl(ss_ctrl), .addr(addr),
    .store_data(store_data), .mem_rdata(rdata[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_wr(mem_wr[1]), .busy(busy[1]),
    .done(done[1]), .illegal(illegal[1])
  );

  function automatic int lat(input int j);
    return (j == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a * 32'h9E37_79B9 + 32'h1357_2468;
  endfunction

  task automatic chk(input string tag, input int j, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[L%0d] observed=%h expected=%h", tag, lat(j), obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int j = 0; j < 2; j++) begin
      chk({tag, "_addr"}, j, mem_addr[j], 32'h0);
      chk({tag, "_wdata"}, j, mem_wdata[j], 32'h0);
      chk({tag, "_wr"}, j, 32'(mem_wr[j]), 32'h0);
      chk({tag, "_busy"}, j, 32'(busy[j]), 32'h0);
      chk({tag, "_done"}, j, 32'(done[j]), 32'h0);
      chk({tag, "_ill"}, j, 32'(illegal[j]), 32'h0);
    end
  endtask

  // noise: 0 quiet, 1 start held high while busy, 2 random start pulses;
  // noise!=0 also scrambles addr/data/ctrl after the launch edge.
  task automatic run_store(input logic [1:0] ctrl, input logic [31:0] a,
                           input logic [31:0] d, input int noise);
    logic [31:0] old_w, exp_w;
    int wr_c[2], dn_c[2];
    int first, last;
    old_w = mem_read(a);
    case (ctrl)
      2'd0:    exp_w = d;
      2'd1:    exp_w = (old_w & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
      2'd2:    exp_w = (old_w & 32'hFFFF_FF00) | (d & 32'h0000_00FF);
      default: exp_w = old_w;
    endcase
    for (int j = 0; j < 2; j++) begin
      if (ctrl == 2'd3)      begin wr_c[j] = -1;         dn_c[j] = 1;          end
      else if (ctrl == 2'd0) begin wr_c[j] = 1;          dn_c[j] = 2;          end
      else                   begin wr_c[j] = lat(j) + 1; dn_c[j] = lat(j) + 2; end
    end
    first = (dn_c[0] < dn_c[1]) ? dn_c[0] : dn_c[1];
    last  = (dn_c[0] > dn_c[1]) ? dn_c[0] : dn_c[1];
    @(negedge clk);
    start = 1'b1; ss_ctrl = ctrl; addr = a; store_data = d;
    rdata[0] = $urandom; rdata[1] = $urandom;
    for (int i = 1; i <= last + 1; i++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        chk("busy", j, 32'(busy[j]), 32'(i <= dn_c[j]));
        chk("done", j, 32'(done[j]), 32'(i == dn_c[j]));
        chk("illegal", j, 32'(illegal[j]), 32'((ctrl == 2'd3) && (i == dn_c[j])));
        chk("mem_wr", j, 32'(mem_wr[j]), 32'(i == wr_c[j]));
        if (i == wr_c[j]) begin
          chk("mem_addr", j, mem_addr[j], a);
          chk("mem_wdata", j, mem_wdata[j], exp_w);
        end
        rdata[j] = (i == lat(j)) ? old_w : $urandom;
      end
      if (noise == 1)      start = (i <= first);
      else if (noise == 2) start = (i <= first) ? 1'($urandom_range(0, 1)) : 1'b0;
      else                 start = 1'b0;
      if (noise != 0) begin
        ss_ctrl = 2'($urandom_range(0, 3)); addr = $urandom; store_data = $urandom;
      end
    end
    start = 1'b0;
    if (ctrl != 2'd3) mem[a] = exp_w;
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; ss_ctrl = 2'd0; addr = 32'h40; store_data = 32'h1234_5678;
    rdata[0] = '0; rdata[1] = '0;
    #1 chk_zero("rst_t0");
    repeat (3) begin
      @(negedge clk);
      chk_zero("rst_hold");
    end
    @(negedge clk);
    start = 1'b0; reset = 1'b1;

    run_store(2'd0, 32'h40, 32'hDEAD_BEEF, 0);
    mem[32'h80] = 32'h1122_3344;
    run_store(2'd1, 32'h80, 32'hAAAA_BBBB, 0);
    mem[32'h84] = 32'h1122_3344;
    run_store(2'd2, 32'h84, 32'h0000_00CC, 0);
    run_store(2'd3, 32'h88, 32'h5555_5555, 0);
    run_store(2'd1, 32'h90, 32'hCAFE_F00D, 1);
    run_store(2'd0, 32'h94, 32'h0BAD_CAFE, 1);

    // Abort an SB while both instances are in READ.
    @(negedge clk);
    start = 1'b1; ss_ctrl = 2'd2; addr = 32'hA0; store_data = 32'h0000_0077;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy", 0, 32'(busy[0]), 32'h1);
    chk("abort_busy", 1, 32'(busy[1]), 32'h1);
    #2 reset = 1'b0;
    #1 chk_zero("abort_async");
    @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        chk("post_abort_wr", j, 32'(mem_wr[j]), 32'h0);
        chk("post_abort_busy", j, 32'(busy[j]), 32'h0);
      end
    end

    for (int n = 0; n < 40; n++)
      run_store(2'($urandom_range(0, 3)), 32'($urandom_range(0, 15)) << 2, $urandom,
                int'($urandom_range(0, 2)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
